cpu_lsu: RTL

CPU_LSU -- requirements
Module: cpu_lsu

---
 rtl/cpu_core_pkg.sv | 57 +++++
 rtl/lsu_data_align.sv | 62 ++++++
 rtl/cpu_lsu.sv | 152 +++++++++++++++
 3 files changed

// File: rtl/cpu_core_pkg.sv
// Shared core definitions: load/store funct3 codes, access sizes, LSU state
// encoding and the access-legality rule used by the load/store unit.
`ifndef XLEN
`define XLEN 32
`endif

package cpu_core_pkg;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;

    // Access size as carried in funct3[1:0]
    localparam logic [1:0] BYTE  = 2'b00;
    localparam logic [1:0] HWORD = 2'b01;
    localparam logic [1:0] WORD  = 2'b10;

    typedef enum logic [1:0] {
        LSU_IDLE = 2'b00,
        LSU_REQ  = 2'b01,
        LSU_WAIT = 2'b10,
        LSU_RESP = 2'b11
    } lsu_state_t;

    function automatic logic lsu_access_legal(
        input logic       is_load,
        input logic       is_store,
        input logic [2:0] funct3,
        input logic [1:0] addr_lo
    );
        logic ok;
        if (is_load == is_store) begin
            ok = 1'b0;
        end else if (is_load) begin
            case (funct3)
                F3_LB, F3_LH, F3_LW, F3_LBU, F3_LHU: ok = 1'b1;
                default:                             ok = 1'b0;
            endcase
        end else begin
            ok = (funct3 < 3'b011);
        end
        if ((funct3[1:0] == HWORD) && addr_lo[0]) begin
            ok = 1'b0;
        end else if ((funct3[1:0] == WORD) && (addr_lo != 2'b00)) begin
            ok = 1'b0;
        end else begin
            ok = ok;
        end
        return ok;
    endfunction

endpackage

// File: rtl/lsu_data_align.sv
// Combinational byte-lane steering for stores and lane extraction plus
// sign/zero extension for loads.
`ifndef XLEN
`define XLEN 32
`endif

module lsu_data_align
    import cpu_core_pkg::*;
#(
    parameter int XLEN = `XLEN
) (
    input  logic [2:0]      i_funct3,
    input  logic [1:0]      i_addr_lo,
    input  logic [XLEN-1:0] i_wdata,
    input  logic [XLEN-1:0] i_rdata,
    output logic [3:0]      o_be,
    output logic [XLEN-1:0] o_wdata,
    output logic [XLEN-1:0] o_rdata
);

    logic [XLEN-1:0] w_shifted;

    assign w_shifted = i_rdata >> {i_addr_lo, 3'b000};

    // Store lanes: narrow data is replicated so every lane carries it
    always_comb begin
        o_be    = 4'b0000;
        o_wdata = '0;
        case (i_funct3[1:0])
            BYTE: begin
                o_be    = 4'b0001 << i_addr_lo;
                o_wdata = {(XLEN/8){i_wdata[7:0]}};
            end
            HWORD: begin
                o_be    = i_addr_lo[1] ? 4'b1100 : 4'b0011;
                o_wdata = {(XLEN/16){i_wdata[15:0]}};
            end
            WORD: begin
                o_be    = 4'b1111;
                o_wdata = i_wdata;
            end
            default: begin
                o_be    = 4'b0000;
                o_wdata = '0;
            end
        endcase
    end

    // Load extraction and extension
    always_comb begin
        o_rdata = '0;
        case (i_funct3)
            F3_LB:   o_rdata = {{(XLEN-8){w_shifted[7]}}, w_shifted[7:0]};
            F3_LH:   o_rdata = {{(XLEN-16){w_shifted[15]}}, w_shifted[15:0]};
            F3_LW:   o_rdata = w_shifted;
            F3_LBU:  o_rdata = {{(XLEN-8){1'b0}}, w_shifted[7:0]};
            F3_LHU:  o_rdata = {{(XLEN-16){1'b0}}, w_shifted[15:0]};
            default: o_rdata = '0;
        endcase
    end

endmodule

// File: rtl/cpu_lsu.sv
// Single-outstanding load/store unit: accepts one memory operation, runs it
// on the request/grant/rvalid bus and returns a one-cycle completion pulse.
`ifndef XLEN
`define XLEN 32
`endif

module cpu_lsu
    import cpu_core_pkg::*;
#(
    parameter int XLEN = `XLEN
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            i_req_valid,
    output logic            o_req_ready,
    input  logic            i_req_is_load,
    input  logic            i_req_is_store,
    input  logic [2:0]      i_req_funct3,
    input  logic [XLEN-1:0] i_req_addr,
    input  logic [XLEN-1:0] i_req_wdata,
    output logic            o_mem_req,
    output logic            o_mem_we,
    output logic [XLEN-1:0] o_mem_addr,
    output logic [3:0]      o_mem_be,
    output logic [XLEN-1:0] o_mem_wdata,
    input  logic            i_mem_gnt,
    input  logic            i_mem_rvalid,
    input  logic [XLEN-1:0] i_mem_rdata,
    output logic            o_rsp_valid,
    output logic [XLEN-1:0] o_rsp_rdata,
    output logic            o_rsp_err
);

    lsu_state_t      r_state;
    lsu_state_t      w_next_state;
    logic            r_is_load;
    logic [2:0]      r_funct3;
    logic [XLEN-1:0] r_addr;
    logic [XLEN-1:0] r_wdata;
    logic [XLEN-1:0] r_rdata;
    logic            r_err;
    logic            w_accept;
    logic            w_legal;
    logic [3:0]      w_be;
    logic [XLEN-1:0] w_lane_wdata;
    logic [XLEN-1:0] w_load_data;

    assign w_accept = i_req_valid && (r_state == LSU_IDLE);
    assign w_legal  = lsu_access_legal(i_req_is_load, i_req_is_store,
                                       i_req_funct3, i_req_addr[1:0]);

    lsu_data_align #(.XLEN(XLEN)) u_align (
        .i_funct3  (r_funct3),
        .i_addr_lo (r_addr[1:0]),
        .i_wdata   (r_wdata),
        .i_rdata   (i_mem_rdata),
        .o_be      (w_be),
        .o_wdata   (w_lane_wdata),
        .o_rdata   (w_load_data)
    );

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= LSU_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Operation capture; load data lands here when the bus returns it
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_is_load <= 1'b0;
            r_funct3  <= 3'b000;
            r_addr    <= '0;
            r_wdata   <= '0;
            r_rdata   <= '0;
            r_err     <= 1'b0;
        end else if (w_accept) begin
            r_is_load <= i_req_is_load;
            r_funct3  <= i_req_funct3;
            r_addr    <= i_req_addr;
            r_wdata   <= i_req_wdata;
            r_rdata   <= '0;
            r_err     <= !w_legal;
        end else if ((r_state == LSU_WAIT) && i_mem_rvalid) begin
            r_rdata <= w_load_data;
        end
    end

    // Next-state logic; illegal accesses skip the bus entirely
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            LSU_IDLE: begin
                if (i_req_valid) begin
                    w_next_state = w_legal ? LSU_REQ : LSU_RESP;
                end else begin
                    w_next_state = LSU_IDLE;
                end
            end
            LSU_REQ: begin
                if (i_mem_gnt) begin
                    w_next_state = r_is_load ? LSU_WAIT : LSU_RESP;
                end else begin
                    w_next_state = LSU_REQ;
                end
            end
            LSU_WAIT: begin
                if (i_mem_rvalid) begin
                    w_next_state = LSU_RESP;
                end else begin
                    w_next_state = LSU_WAIT;
                end
            end
            LSU_RESP: w_next_state = LSU_IDLE;
            default:  w_next_state = LSU_IDLE;
        endcase
    end

    // Outputs decoded from state; bus fields are zero outside REQ
    always_comb begin
        o_req_ready = 1'b0;
        o_mem_req   = 1'b0;
        o_mem_we    = 1'b0;
        o_mem_addr  = '0;
        o_mem_be    = 4'b0000;
        o_mem_wdata = '0;
        o_rsp_valid = 1'b0;
        o_rsp_rdata = '0;
        o_rsp_err   = 1'b0;
        case (r_state)
            LSU_IDLE: o_req_ready = 1'b1;
            LSU_REQ: begin
                o_mem_req   = 1'b1;
                o_mem_we    = !r_is_load;
                o_mem_addr  = {r_addr[XLEN-1:2], 2'b00};
                o_mem_be    = w_be;
                o_mem_wdata = r_is_load ? '0 : w_lane_wdata;
            end
            LSU_WAIT: o_req_ready = 1'b0;
            LSU_RESP: begin
                o_rsp_valid = 1'b1;
                o_rsp_rdata = r_rdata;
                o_rsp_err   = r_err;
            end
            default: o_req_ready = 1'b0;
        endcase
    end

endmodule
